// File: rtl/counter_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_reader_pkg
//  Description : Shared types and default constants for the counter delta
//                reader: FSM state encoding and default parameter values.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_reader_pkg;

  localparam int c_DEFAULT_N_BITS     = 8;
  localparam int c_DEFAULT_SAMPLE_DIV = 16;
  localparam int c_DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage : counter_reader_pkg
`default_nettype wire

// File: rtl/delta_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : delta_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head entry is
//                visible on o_rdata one edge after it is written.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                i_push, i_wdata   - write request and data
//                i_pop             - consume head entry
//                o_rdata           - head entry (0 when empty)
//                o_full, o_empty   - status flags
//                o_level           - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module delta_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (PTR_W+1)'(DEPTH));

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push
  // when it is being popped. Pointers wrap naturally since DEPTH is 2^PTR_W.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule : delta_fifo
`default_nettype wire

// File: rtl/counter_delta_reader.sv
`default_nettype none
// ============================================================================
//  Module      : counter_delta_reader
//  Description : Periodically samples a free-running counter and queues the
//                modular difference between consecutive samples in a FIFO.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                enable           - sampling enable
//                count_value      - counter being read
//                clear_overflow   - clears sticky overflow flag
//                delta_data/valid - head-of-FIFO delta and its valid flag
//                delta_ready      - consumer accepts head entry
//                overflow         - sticky: a delta was dropped
//                fifo_level       - number of queued deltas
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_delta_reader
  import counter_reader_pkg::*;
#(
  parameter int N_BITS     = c_DEFAULT_N_BITS,
  parameter int SAMPLE_DIV = c_DEFAULT_SAMPLE_DIV,
  parameter int FIFO_DEPTH = c_DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [N_BITS-1:0]             count_value,
  input  logic                          clear_overflow,
  output logic [N_BITS-1:0]             delta_data,
  output logic                          delta_valid,
  input  logic                          delta_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  state_t              r_state;
  state_t              w_state_next;
  logic [DIV_W-1:0]    r_div;
  logic [N_BITS-1:0]   r_prev;
  logic                r_overflow;

  logic                w_div_wrap;
  logic                w_capture;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic [N_BITS-1:0]   w_delta;

  assign w_div_wrap = (r_div == DIV_W'(SAMPLE_DIV - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: dropping enable returns to IDLE from anywhere, so the
  // next enable always re-primes before producing a delta.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_next = PRIME;
      PRIME:   if (!enable) w_state_next = IDLE;
               else if (w_div_wrap) w_state_next = RUN;
      RUN:     if (!enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: sampling actions on a divider tick; no sample is taken on
  // the edge where enable has already been withdrawn.
  always_comb begin
    w_capture = 1'b0;
    w_push    = 1'b0;
    if (enable && w_div_wrap) begin
      w_capture = (r_state == PRIME);
      w_push    = (r_state == RUN);
    end
  end

  // Modular subtraction handles counter wrap-around without special casing.
  assign w_delta = count_value - r_prev;

  // Pop decision depends only on registered FIFO state, so a freshly pushed
  // entry cannot be popped on the edge it is written.
  assign w_pop  = delta_valid && delta_ready;
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_prev     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == IDLE || w_state_next == IDLE || w_div_wrap) r_div <= '0;
      else                                                       r_div <= r_div + DIV_W'(1);

      // The reference sample advances even when its delta is dropped.
      if (w_capture || w_push) r_prev <= count_value;

      // A drop on the same edge wins over a clear request.
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  delta_fifo #(
    .WIDTH (N_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_delta),
    .i_pop   (w_pop),
    .o_rdata (delta_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign delta_valid = !w_empty;
  assign overflow    = r_overflow;

endmodule : counter_delta_reader
`default_nettype wire

// File: tb/tb_counter_delta_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_delta_reader
//  Description : Directed self-checking bench for counter_delta_reader with
//                N_BITS=8, SAMPLE_DIV=4, FIFO_DEPTH=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_delta_reader;

  localparam int N_BITS     = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [N_BITS-1:0] count_value;
  logic              clear_overflow;
  logic [N_BITS-1:0] delta_data;
  logic              delta_valid;
  logic              delta_ready;
  logic              overflow;
  logic [LVL_W-1:0]  fifo_level;

  bit   auto_cnt;
  int   n_checks;
  int   n_pass;
  logic any_v;
  int   n_seen;

  counter_delta_reader #(
    .N_BITS     (N_BITS),
    .SAMPLE_DIV (SAMPLE_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .count_value    (count_value),
    .clear_overflow (clear_overflow),
    .delta_data     (delta_data),
    .delta_valid    (delta_valid),
    .delta_ready    (delta_ready),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge; outputs are examined 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_cnt) count_value = count_value + 8'd1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset, then enable: on return the edge taking IDLE->PRIME has just passed,
  // so the PRIME tick is 4 edges later and RUN ticks every 4 edges after that.
  task automatic start(input bit auto_mode);
    auto_cnt       = auto_mode;
    count_value    = '0;
    reset          = 1'b1;
    enable         = 1'b0;
    clear_overflow = 1'b0;
    delta_ready    = 1'b0;
    step();
    reset  = 1'b0;
    enable = 1'b1;
    step();
  endtask

  // Hold count_value at v and advance to the next tick edge.
  task automatic run_to_tick(input logic [N_BITS-1:0] v);
    count_value = v;
    steps(4);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset dominates active inputs.
    auto_cnt       = 1'b0;
    reset          = 1'b1;
    enable         = 1'b1;
    delta_ready    = 1'b1;
    clear_overflow = 1'b0;
    count_value    = 8'h55;
    steps(2);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_valid", 32'(delta_valid), 32'd0);
    check("rst_data",  32'(delta_data), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);

    // Steady run, consumer always ready: first delta 4 edges after PRIME tick.
    start(1'b1);
    delta_ready = 1'b1;
    steps(7);
    check("first_not_yet", 32'(delta_valid), 32'd0);
    step();
    check("first_valid", 32'(delta_valid), 32'd1);
    check("first_data",  32'(delta_data), 32'h04);
    check("first_level", 32'(fifo_level), 32'd1);
    step();
    check("first_popped", 32'(fifo_level), 32'd0);
    n_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (delta_valid) begin
        n_seen++;
        check("steady_data", 32'(delta_data), 32'h04);
      end
    end
    check("steady_count", 32'(n_seen), 32'd3);
    check("steady_ovf",   32'(overflow), 32'd0);

    // Wrap-around: 0xFE then 0x02 gives 0x04; head held while not ready.
    start(1'b0);
    run_to_tick(8'hFE);
    run_to_tick(8'h02);
    check("wrap_data", 32'(delta_data), 32'h04);
    step();
    check("hold_data",  32'(delta_data), 32'h04);
    check("hold_level", 32'(fifo_level), 32'd1);

    // Overflow: five RUN ticks with consumer stalled, distinct deltas.
    start(1'b0);
    run_to_tick(8'd10);
    run_to_tick(8'd13);
    check("ovf_l1",   32'(fifo_level), 32'd1);
    check("ovf_head", 32'(delta_data), 32'd3);
    run_to_tick(8'd18);
    check("ovf_l2", 32'(fifo_level), 32'd2);
    run_to_tick(8'd25);
    check("ovf_l3", 32'(fifo_level), 32'd3);
    run_to_tick(8'd34);
    check("ovf_l4",    32'(fifo_level), 32'd4);
    check("ovf_not_yet", 32'(overflow), 32'd0);
    clear_overflow = 1'b1;   // drop on this edge must win over the clear
    run_to_tick(8'd45);
    check("ovf_full_level", 32'(fifo_level), 32'd4);
    check("ovf_set",        32'(overflow), 32'd1);
    check("ovf_head_kept",  32'(delta_data), 32'd3);
    count_value = 8'd50;
    delta_ready = 1'b1;
    step();
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("drain_2",     32'(delta_data), 32'd5);
    clear_overflow = 1'b0;
    step();
    check("drain_3", 32'(delta_data), 32'd7);
    step();
    check("drain_4", 32'(delta_data), 32'd9);
    step();
    // 50 - 45: the reference advanced despite the dropped delta.
    check("post_drop_data",  32'(delta_data), 32'd5);
    check("post_drop_level", 32'(fifo_level), 32'd1);
    step();
    check("post_drop_empty", 32'(fifo_level), 32'd0);

    // Full FIFO with a pop on the tick edge: both accepted.
    start(1'b0);
    run_to_tick(8'd0);
    run_to_tick(8'd4);
    run_to_tick(8'd8);
    run_to_tick(8'd12);
    run_to_tick(8'd16);
    check("full_level", 32'(fifo_level), 32'd4);
    count_value = 8'd20;
    steps(3);
    delta_ready = 1'b1;
    step();
    check("full_pushpop_level", 32'(fifo_level), 32'd4);
    check("full_pushpop_ovf",   32'(overflow), 32'd0);
    delta_ready = 1'b0;

    // Reset mid-RUN with three entries queued, enable held high.
    start(1'b1);
    steps(16);
    check("mid_level", 32'(fifo_level), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_valid", 32'(delta_valid), 32'd0);
    any_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      any_v = any_v | delta_valid;
    end
    check("reprime_quiet", 32'(any_v), 32'd0);
    step();
    check("reprime_valid", 32'(delta_valid), 32'd1);
    check("reprime_data",  32'(delta_data), 32'h04);

    // Disable with two entries queued: they drain, nothing new arrives.
    start(1'b1);
    steps(12);
    check("dis_level", 32'(fifo_level), 32'd2);
    enable      = 1'b0;
    delta_ready = 1'b1;
    step();
    check("dis_drain1_data",  32'(delta_data), 32'h04);
    check("dis_drain1_level", 32'(fifo_level), 32'd1);
    step();
    check("dis_drain2_level", 32'(fifo_level), 32'd0);
    any_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      any_v = any_v | delta_valid;
    end
    check("dis_no_push", 32'(any_v), 32'd0);
    enable = 1'b1;
    any_v  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      any_v = any_v | delta_valid;
    end
    check("reen_no_stale", 32'(any_v), 32'd0);
    step();
    check("reen_valid", 32'(delta_valid), 32'd1);
    check("reen_data",  32'(delta_data), 32'h04);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_counter_delta_reader
`default_nettype wire

// File: doc/counter_delta_reader.md
COUNTER_DELTA_READER -- requirements
Module: counter_delta_reader

Interface
REQ-001 Parameter N_BITS, default 8: width of the sampled counter value and of each delta word.
REQ-002 Parameter SAMPLE_DIV, default 16: sampling period in clk cycles; legal range is 2 or more.
REQ-003 Parameter FIFO_DEPTH, default 4: number of delta entries buffered; must be a power of 2, 2 or more.
REQ-004 Port list (name, direction, width, meaning) SHALL be:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: sampling enable.
- count_value, input, N_BITS: free-running wrapping up-counter to be read; synchronous to clk.
- clear_overflow, input, 1: clears the sticky overflow flag.
- delta_data, output, N_BITS: head-of-FIFO delta.
- delta_valid, output, 1: delta_data holds a valid entry.
- delta_ready, input, 1: consumer accepts the current entry.
- overflow, output, 1: sticky flag; a delta was dropped.
- fifo_level, output, clog2(FIFO_DEPTH)+1: current number of stored entries.

Function
REQ-005 FSM states SHALL be IDLE, PRIME and RUN.
REQ-006 In IDLE, the divider SHALL hold at 0 and no samples SHALL be taken.
REQ-007 IDLE->PRIME when enable=1; any state->IDLE when enable=0, taking effect at the next edge.
REQ-008 Outside IDLE, the divider SHALL count 0..SAMPLE_DIV-1 and wrap; tick = (divider==SAMPLE_DIV-1).
REQ-009 On a PRIME tick, count_value SHALL be captured into prev_sample, nothing is pushed, and the FSM moves to RUN.
REQ-010 On a RUN tick, delta = (count_value - prev_sample) mod 2^N_BITS is pushed, and prev_sample <= count_value.
REQ-011 Wrap-around SHALL be handled by modular subtraction only; prev=0xFE, cur=0x02 yields 0x04 (N_BITS=8).
REQ-012 Push-to-visibility latency SHALL be 1 edge: an entry pushed at edge k appears on delta_data/delta_valid after edge k (first-word fall-through).
REQ-013 Pop SHALL occur on each edge where delta_valid and delta_ready are both 1.
REQ-014 While delta_valid=1 and delta_ready=0, delta_data SHALL be held stable.
REQ-015 delta_valid SHALL equal (fifo_level != 0).
REQ-016 Push into a full FIFO with no simultaneous pop: the entry SHALL be dropped, overflow SHALL be set, and prev_sample SHALL still update.
REQ-017 Push into a full FIFO with a simultaneous pop: both SHALL be accepted and the level stays FIFO_DEPTH.
REQ-018 Push into an empty FIFO with delta_ready=1: no pop SHALL occur that edge (the entry is not yet visible).
REQ-019 Priority: clear_overflow=1 clears overflow, except when a drop occurs on the same edge, in which case overflow SHALL stay 1.
REQ-020 Returning to IDLE SHALL NOT flush the FIFO; draining continues.
REQ-021 Re-entering PRIME from IDLE SHALL re-prime, so no delta spans the disabled interval.

Reset
REQ-022 On reset=1 at an edge: state=IDLE, divider=0, prev_sample=0, FIFO empty, fifo_level=0, delta_valid=0, delta_data=0, overflow=0.
REQ-023 Reset SHALL override all other inputs, including mid-RUN and during a simultaneous push/pop; FIFO contents are discarded.

Structure
REQ-024 A shared package counter_reader_pkg SHALL hold the FSM state enum (IDLE, PRIME, RUN) and the default parameter constants.
REQ-025 Storage SHALL be a sub-module delta_fifo: a synchronous FWFT FIFO with push/pop/full/empty/level, on the same clk and reset.
REQ-026 The subtractor and FSM SHALL live in counter_delta_reader; there SHALL be no combinational path from delta_ready to delta_data.

Verification (N_BITS=8, SAMPLE_DIV=4, FIFO_DEPTH=4, count_value +1 per cycle unless noted)
REQ-027 enable=1, delta_ready=1 -> first entry valid 4 cycles after the PRIME tick; every delta = 0x04; overflow stays 0.
REQ-028 count_value forced to 0xFE at prime, then 0x02 at the next tick -> delta_data = 0x04.
REQ-029 delta_ready=0 for 5 RUN ticks -> fifo_level=4, overflow=1, drained entries are the first four deltas in order; clear_overflow=1 -> overflow=0.
REQ-030 FIFO full, delta_ready=1 on a tick edge -> fifo_level stays 4, overflow stays 0.
REQ-031 reset=1 for 1 cycle mid-RUN with fifo_level=3 -> next cycle level=0, delta_valid=0, state IDLE; with enable held at 1, re-primes and the first delta is 0x04.
REQ-032 enable dropped with 2 entries queued -> both drain with delta_ready=1; no new pushes; re-enable -> PRIME with no stale delta.
